corr_score_engine: RTL and testbench

CORR_SCORE_ENGINE -- requirements
Module: corr_score_engine

---
 rtl/corr_pkg.sv | 32 +++
 rtl/corr_valid_pipe.sv | 40 ++++
 rtl/corr_score_engine.sv | 188 ++++++++++++++++++
 tb/tb_corr_score_engine.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : corr_pkg
// Purpose  : Shared definitions for the correlation score engine: FSM state
//            encoding, score-width derivation and max-pixel helpers.
// Revision : 1.0  initial release
// ============================================================================
package corr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } corr_state_t;

  // Default pixel width and its full-scale value.
  localparam int DEF_PIX_W   = 10;
  localparam int DEF_MAX_PIX = (1 << DEF_PIX_W) - 1;

  // Full-scale pixel value for an arbitrary pixel width.
  function automatic int max_pix(input int pix_w);
    return (1 << pix_w) - 1;
  endfunction

  // Accumulator width that can hold TPL_W*TPL_H full-scale similarities.
  function automatic int score_w(input int pix_w, input int tpl_w, input int tpl_h);
    return pix_w + $clog2(tpl_w * tpl_h);
  endfunction

endpackage
`default_nettype wire

// File: rtl/corr_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : corr_valid_pipe
// Purpose  : DEPTH-stage delay line that aligns the "address issued" flag
//            with the memory read data returning DEPTH cycles later.
// Ports    : clk       - clock
//            rst       - synchronous active-high reset, clears all stages
//            in_valid  - flag for the address issued this cycle
//            out_valid - same flag delayed by DEPTH cycles
// Revision : 1.0  initial release
// ============================================================================
module corr_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] stages;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) stages <= '0;
        else     stages <= in_valid;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) stages <= '0;
        else     stages <= {stages[DEPTH-2:0], in_valid};
      end
    end
  endgenerate

  assign out_valid = stages[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/corr_score_engine.sv
`default_nettype none
// ============================================================================
// Module   : corr_score_engine
// Purpose  : Scans a TPL_W x TPL_H window of an image against a template,
//            accumulating per-pixel similarity (max - |img - tpl|) into a
//            window score, and tracks the best-scoring window origin.
// Ports    : iCLK, iRST            - clock, synchronous active-high reset
//            iStart                - start request (accepted only when idle)
//            iXstart, iYstart      - window origin, sampled on accept
//            iClr_best             - clear best-match tracker
//            reading_sram/search   - image/template read data (RD_LAT late)
//            oX_sram, oY_sram      - image address (origin + offset, wraps)
//            oX_search, oY_search  - template address (offset)
//            oBusy, oDone, oScore  - status and window result
//            oBest_*               - best-match tracker outputs
// Revision : 1.0  initial release
// ============================================================================
module corr_score_engine
  import corr_pkg::*;
#(
  parameter  int PIX_W   = 10,
  parameter  int COORD_W = 13,
  parameter  int TPL_W   = 64,
  parameter  int TPL_H   = 48,
  parameter  int RD_LAT  = 1,
  localparam int SCORE_W = score_w(PIX_W, TPL_W, TPL_H)
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iStart,
  input  logic [COORD_W-1:0] iXstart,
  input  logic [COORD_W-1:0] iYstart,
  input  logic               iClr_best,
  input  logic [PIX_W-1:0]   reading_sram,
  input  logic [PIX_W-1:0]   reading_search,
  output logic [COORD_W-1:0] oX_sram,
  output logic [COORD_W-1:0] oY_sram,
  output logic [COORD_W-1:0] oX_search,
  output logic [COORD_W-1:0] oY_search,
  output logic               oBusy,
  output logic               oDone,
  output logic [SCORE_W-1:0] oScore,
  output logic [SCORE_W-1:0] oBest_score,
  output logic [COORD_W-1:0] oBest_X,
  output logic [COORD_W-1:0] oBest_Y,
  output logic               oBest_valid
);

  localparam int XW = $clog2(TPL_W);
  localparam int YW = (TPL_H > 1) ? $clog2(TPL_H) : 1;

  localparam logic [PIX_W-1:0] MAX_PIX = PIX_W'(max_pix(PIX_W));
  localparam logic [XW-1:0]    X_LAST  = XW'(TPL_W - 1);
  localparam logic [YW-1:0]    Y_LAST  = YW'(TPL_H - 1);
  localparam logic [2:0]       D_LAST  = 3'(RD_LAT - 1);

  corr_state_t        state;
  corr_state_t        state_nxt;
  logic [XW-1:0]      x_off;
  logic [YW-1:0]      y_off;
  logic [COORD_W-1:0] x_org;
  logic [COORD_W-1:0] y_org;
  logic [2:0]         drain_cnt;
  logic [SCORE_W-1:0] acc;
  logic [SCORE_W-1:0] acc_nxt;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] best_score;
  logic [COORD_W-1:0] best_x;
  logic [COORD_W-1:0] best_y;
  logic               best_valid;
  logic [PIX_W-1:0]   pix_diff;
  logic [PIX_W-1:0]   pix_sim;
  logic               accept;
  logic               scan_last;
  logic               issuing;
  logic               rd_valid;
  logic               drain_end;
  logic               best_load;

  assign accept    = (state == ST_IDLE) && iStart;
  assign scan_last = (x_off == X_LAST) && (y_off == Y_LAST);
  assign issuing   = (state == ST_SCAN);
  assign drain_end = (state == ST_DRAIN) && (drain_cnt == D_LAST);

  // Marks which cycles carry read data belonging to the current window.
  corr_valid_pipe #(
    .DEPTH (RD_LAT)
  ) u_valid_pipe (
    .clk       (iCLK),
    .rst       (iRST),
    .in_valid  (issuing),
    .out_valid (rd_valid)
  );

  // Absolute difference taken in the larger-minus-smaller direction so the
  // subtraction never wraps; similarity is then bounded by MAX_PIX.
  always_comb begin
    pix_diff = (reading_sram >= reading_search) ? (reading_sram - reading_search)
                                                : (reading_search - reading_sram);
    pix_sim  = MAX_PIX - pix_diff;
    acc_nxt  = rd_valid ? (acc + SCORE_W'(pix_sim)) : acc;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (iStart)    state_nxt = ST_SCAN;
      ST_SCAN:  if (scan_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_end) state_nxt = ST_DONE;
      ST_DONE:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // A coincident clear still lets the finishing window become the new best.
  assign best_load = (state == ST_DONE) &&
                     (iClr_best || !best_valid || (score > best_score));

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= ST_IDLE;
      x_off      <= '0;
      y_off      <= '0;
      x_org      <= '0;
      y_org      <= '0;
      drain_cnt  <= '0;
      acc        <= '0;
      score      <= '0;
      best_score <= '0;
      best_x     <= '0;
      best_y     <= '0;
      best_valid <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        x_org <= iXstart;
        y_org <= iYstart;
        acc   <= '0;
      end else begin
        acc <= acc_nxt;
      end

      // Raster walk; offsets return to zero after the last position so they
      // read as zero in every non-SCAN state.
      if (issuing) begin
        if (x_off == X_LAST) begin
          x_off <= '0;
          y_off <= (y_off == Y_LAST) ? '0 : (y_off + 1'b1);
        end else begin
          x_off <= x_off + 1'b1;
        end
      end

      if (issuing)                drain_cnt <= '0;
      else if (state == ST_DRAIN) drain_cnt <= drain_cnt + 3'd1;

      // acc_nxt already contains the final pixel on the last DRAIN cycle.
      if (drain_end) score <= acc_nxt;

      if (best_load) begin
        best_score <= score;
        best_x     <= x_org;
        best_y     <= y_org;
        best_valid <= 1'b1;
      end else if (iClr_best) begin
        best_score <= '0;
        best_x     <= '0;
        best_y     <= '0;
        best_valid <= 1'b0;
      end
    end
  end

  assign oX_sram     = x_org + COORD_W'(x_off);
  assign oY_sram     = y_org + COORD_W'(y_off);
  assign oX_search   = COORD_W'(x_off);
  assign oY_search   = COORD_W'(y_off);
  assign oBusy       = (state != ST_IDLE);
  assign oDone       = (state == ST_DONE);
  assign oScore      = score;
  assign oBest_score = best_score;
  assign oBest_X     = best_x;
  assign oBest_Y     = best_y;
  assign oBest_valid = best_valid;

endmodule
`default_nettype wire

// File: tb/tb_corr_score_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_corr_score_engine
// Purpose  : Self-checking bench for corr_score_engine with a 4x2 template,
//            10-bit pixels and a two-cycle read latency memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_corr_score_engine;

  localparam int PIX_W   = 10;
  localparam int COORD_W = 13;
  localparam int TPL_W   = 4;
  localparam int TPL_H   = 2;
  localparam int RD_LAT  = 2;
  localparam int SW      = 13;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [COORD_W-1:0] xs, ys;
  logic               clr;
  logic [PIX_W-1:0]   rd_img, rd_tpl;
  logic [COORD_W-1:0] x_sram, y_sram, x_srch, y_srch;
  logic               busy, done, best_valid;
  logic [SW-1:0]      score, best_score;
  logic [COORD_W-1:0] best_x, best_y;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  corr_score_engine #(
    .PIX_W(PIX_W), .COORD_W(COORD_W), .TPL_W(TPL_W), .TPL_H(TPL_H), .RD_LAT(RD_LAT)
  ) dut (
    .iCLK(clk), .iRST(rst), .iStart(start), .iXstart(xs), .iYstart(ys),
    .iClr_best(clr), .reading_sram(rd_img), .reading_search(rd_tpl),
    .oX_sram(x_sram), .oY_sram(y_sram), .oX_search(x_srch), .oY_search(y_srch),
    .oBusy(busy), .oDone(done), .oScore(score), .oBest_score(best_score),
    .oBest_X(best_x), .oBest_Y(best_y), .oBest_valid(best_valid)
  );

  // Memory model: window contents indexed by offset, data returned two
  // cycles after the address.
  logic [7:0][9:0]    img_cur, tpl_cur;
  logic [COORD_W-1:0] sx1, sx2, sy1, sy2;
  logic [2:0]         ridx;
  always @(posedge clk) begin
    sx1 <= x_srch; sx2 <= sx1;
    sy1 <= y_srch; sy2 <= sy1;
  end
  assign ridx   = {sy2[0], sx2[1:0]};
  assign rd_img = img_cur[ridx];
  assign rd_tpl = tpl_cur[ridx];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " score"}, 32'(score), 0);
    chk({tag, " x_sram"}, 32'(x_sram), 0);
    chk({tag, " y_sram"}, 32'(y_sram), 0);
    chk({tag, " x_srch"}, 32'(x_srch), 0);
    chk({tag, " y_srch"}, 32'(y_srch), 0);
    chk({tag, " best_score"}, 32'(best_score), 0);
    chk({tag, " best_xy"}, {3'b0, best_x, 3'b0, best_y}, 0);
    chk({tag, " best_valid"}, 32'(best_valid), 0);
  endtask

  // One window: start, optional address tracking / stray start / clear at
  // DONE, then latency, score and tracker checks.
  task automatic run_window(input string tag,
                            input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                            input bit chk_addr, input bit stray, input bit clr_done,
                            input int exp_score,
                            input int exp_bs, input int exp_bx, input int exp_by);
    int cnt;
    logic [COORD_W-1:0] ex, ey;
    @(negedge clk);
    xs = x; ys = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; xs = '0; ys = '0;
    cnt = 1;
    chk({tag, " busy_after_accept"}, 32'(busy), 1);
    while (cnt < 40) begin
      if (done) break;
      if (chk_addr && cnt <= 8) begin
        ex = x + COORD_W'((cnt - 1) % 4);
        ey = y + COORD_W'((cnt - 1) / 4);
        chk($sformatf("%s x_sram[%0d]", tag, cnt - 1), 32'(x_sram), 32'(ex));
        chk($sformatf("%s y_sram[%0d]", tag, cnt - 1), 32'(y_sram), 32'(ey));
        chk($sformatf("%s x_srch[%0d]", tag, cnt - 1), 32'(x_srch), 32'((cnt - 1) % 4));
      end
      if (stray && cnt == 4) begin start = 1'b1; xs = 13'd99; ys = 13'd99; end
      if (stray && cnt == 5) begin start = 1'b0; xs = '0; ys = '0; end
      @(negedge clk);
      cnt++;
    end
    chk({tag, " done_latency"}, 32'(cnt), 11);
    chk({tag, " score"}, 32'(score), 32'(exp_score));
    if (clr_done) clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk({tag, " idle_busy"}, 32'(busy), 0);
    chk({tag, " idle_done"}, 32'(done), 0);
    chk({tag, " idle_offsets"}, {3'b0, x_srch, 3'b0, y_srch}, 0);
    chk({tag, " score_held"}, 32'(score), 32'(exp_score));
    chk({tag, " best_score"}, 32'(best_score), 32'(exp_bs));
    chk({tag, " best_x"}, 32'(best_x), 32'(exp_bx));
    chk({tag, " best_y"}, 32'(best_y), 32'(exp_by));
    chk({tag, " best_valid"}, 32'(best_valid), 1);
  endtask

  typedef struct {
    logic [COORD_W-1:0] x, y;
    logic [7:0][9:0]    img, tpl;
    int                 score;
    int                 bs, bx, by;
  } vec_t;

  vec_t vecs[6];
  logic [7:0][9:0] ramp, zeros, ones, alt, pat5;

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; clr = 1'b0; xs = '0; ys = '0;
    zeros = {8{10'd0}};
    ones  = {8{10'd1023}};
    ramp  = {10'd1023, 10'd600, 10'd500, 10'd400, 10'd300, 10'd200, 10'd100, 10'd0};
    alt   = {4{10'd10, 10'd0}};
    pat5  = {8{10'd5}};
    img_cur = zeros; tpl_cur = zeros;

    // img, tpl, expected score, expected best after the run
    vecs[0] = '{13'd1,  13'd2,  ones, zeros, 0,    0,    1,  2};
    vecs[1] = '{13'd10, 13'd20, ramp, ramp, 8184, 8184, 10, 20};
    vecs[2] = '{13'd30, 13'd40, {8{10'd77}}, {8{10'd77}}, 8184, 8184, 10, 20};
    vecs[3] = '{13'd3,  13'd4,  {{7{10'd0}}, 10'd10}, zeros, 8174, 8184, 10, 20};
    vecs[4] = '{13'd5,  13'd6,  pat5, alt, 8144, 8184, 10, 20};
    vecs[5] = '{13'd7,  13'd8,  {{6{10'd0}}, 10'd0, 10'd1023},
                                {{6{10'd0}}, 10'd1023, 10'd0}, 6138, 8184, 10, 20};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_all_zero("reset");

    for (int i = 0; i < 6; i++) begin
      img_cur = vecs[i].img;
      tpl_cur = vecs[i].tpl;
      run_window($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, 1'b0, 1'b0, 1'b0,
                 vecs[i].score, vecs[i].bs, vecs[i].bx, vecs[i].by);
    end

    // Clear alone empties the tracker.
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr best_valid", 32'(best_valid), 0);
    chk("clr best_score", 32'(best_score), 0);
    chk("clr best_xy", {3'b0, best_x, 3'b0, best_y}, 0);

    // Origin wrap across 2^COORD_W.
    img_cur = pat5; tpl_cur = alt;
    run_window("wrap", 13'd8190, 13'd5, 1'b1, 1'b0, 1'b0, 8144, 8144, 8190, 5);

    // Start pulsed mid-SCAN is ignored.
    img_cur = ramp; tpl_cur = ramp;
    run_window("stray", 13'd50, 13'd60, 1'b1, 1'b1, 1'b0, 8184, 8184, 50, 60);
    dcount = 0;
    repeat (15) begin @(negedge clk); if (done) dcount++; end
    chk("stray extra_done", 32'(dcount), 0);

    // Reset during DRAIN aborts; reset dominates start and clear.
    @(negedge clk); xs = 13'd70; ys = 13'd71; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    chk("drain busy", 32'(busy), 1);
    chk("drain offsets", {3'b0, x_srch, 3'b0, y_srch}, 0);
    rst = 1'b1; start = 1'b1; clr = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; clr = 1'b0;
    chk_all_zero("abort");
    dcount = 0;
    repeat (15) begin @(negedge clk); if (done || busy) dcount++; end
    chk("abort no_done", 32'(dcount), 0);

    img_cur = vecs[5].img; tpl_cur = vecs[5].tpl;
    run_window("fresh", 13'd11, 13'd12, 1'b0, 1'b0, 1'b0, 6138, 6138, 11, 12);

    // Clear coincident with DONE loads the lower new score.
    img_cur = ones; tpl_cur = zeros;
    run_window("clr_done", 13'd15, 13'd16, 1'b0, 1'b0, 1'b1, 0, 0, 15, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
